// File: rtl/time_counter_if.sv
// rtl/time_counter_if.sv - button inputs and time display bus of the time_counter core
interface time_counter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] digOra;
  logic [5:0] digMinut;
  logic [5:0] digSec;
  logic       sec_tick;
  logic       edit_ora;
  logic       edit_min;
  logic       pm;

  // Driver side: presses the buttons and watches the display.
  modport master (
    output btn_mode, btn_inc,
    input  digOra, digMinut, digSec, sec_tick, edit_ora, edit_min, pm
  );

  // Core side: reads the buttons and drives the display.
  modport slave (
    input  btn_mode, btn_inc,
    output digOra, digMinut, digSec, sec_tick, edit_ora, edit_min, pm
  );
endinterface

// File: rtl/time_counter.sv
// rtl/time_counter.sv - 24h seconds/minutes/hours counter with button set mode (optional DISP_12H_EN)
module time_counter #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic         clk,
  input  logic         reset_,
  time_counter_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {RUN, SET_ORA, SET_MIN} state_t;

  state_t        state, state_n;
  logic          btn_mode_q, btn_inc_q;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    hour, hour_n;
  logic [5:0]    minute, minute_n;
  logic [5:0]    second, second_n;
  logic          tick_n;
  logic          mode_evt, inc_evt;

  logic [4:0]    dig_ora_r;
  logic [5:0]    dig_min_r, dig_sec_r;
  logic          sec_tick_r, edit_ora_r, edit_min_r, pm_r;

  // Display form of the internal 0..23 hour.
  function automatic logic [4:0] disp_hour(input logic [4:0] h);
`ifdef DISP_12H_EN
    if (h == 5'd0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
`else
    return h;
`endif
  endfunction

  // PM flag for the internal hour; only meaningful in the 12-hour build.
  function automatic logic pm_of(input logic [4:0] h);
`ifdef DISP_12H_EN
    return (h >= 5'd12);
`else
    return (h == 5'd0) & 1'b0;
`endif
  endfunction

  assign mode_evt = bus.btn_mode & ~btn_mode_q;
  assign inc_evt  = bus.btn_inc  & ~btn_inc_q;

  // Next-state and next-count logic; a mode press always wins over an inc press.
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    hour_n   = hour;
    minute_n = minute;
    second_n = second;
    tick_n   = 1'b0;
    case (state)
      RUN: begin
        if (mode_evt) begin
          // Freeze at the current count; a coinciding tick is dropped.
          state_n = SET_ORA;
        end else if (presc == PRESC_LAST) begin
          presc_n = '0;
          tick_n  = 1'b1;
          if (second == 6'd59) begin
            second_n = 6'd0;
            if (minute == 6'd59) begin
              minute_n = 6'd0;
              hour_n   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              minute_n = minute + 6'd1;
            end
          end else begin
            second_n = second + 6'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      SET_ORA: begin
        if (mode_evt)
          state_n = SET_MIN;
        else if (inc_evt)
          hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end
      SET_MIN: begin
        if (mode_evt) begin
          // Restart the second cleanly so the first tick is a full period away.
          state_n  = RUN;
          second_n = 6'd0;
          presc_n  = '0;
        end else if (inc_evt) begin
          minute_n = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // State, counters, button history and registered outputs all update together.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state      <= RUN;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      presc      <= '0;
      hour       <= 5'd0;
      minute     <= 6'd0;
      second     <= 6'd0;
      dig_ora_r  <= disp_hour(5'd0);
      dig_min_r  <= 6'd0;
      dig_sec_r  <= 6'd0;
      sec_tick_r <= 1'b0;
      edit_ora_r <= 1'b0;
      edit_min_r <= 1'b0;
      pm_r       <= 1'b0;
    end else begin
      state      <= state_n;
      btn_mode_q <= bus.btn_mode;
      btn_inc_q  <= bus.btn_inc;
      presc      <= presc_n;
      hour       <= hour_n;
      minute     <= minute_n;
      second     <= second_n;
      dig_ora_r  <= disp_hour(hour_n);
      dig_min_r  <= minute_n;
      dig_sec_r  <= second_n;
      sec_tick_r <= tick_n;
      edit_ora_r <= (state_n == SET_ORA);
      edit_min_r <= (state_n == SET_MIN);
      pm_r       <= pm_of(hour_n);
    end
  end

  assign bus.digOra   = dig_ora_r;
  assign bus.digMinut = dig_min_r;
  assign bus.digSec   = dig_sec_r;
  assign bus.sec_tick = sec_tick_r;
  assign bus.edit_ora = edit_ora_r;
  assign bus.edit_min = edit_min_r;
  assign bus.pm       = pm_r;

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Timekeeping core for the digital clock. Counts seconds, minutes and hours (24h) from the system clock through a parameterised prescaler.
- Provides a button-driven set mode for adjusting hours and minutes.
- Drives the binary hour and minute buses consumed directly by the digit-split stage (digOra/digMinut to BCD digits).

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 2; prescaler width = $clog2(TICKS_PER_SEC).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_  input  1  reset, synchronous, active-low
- btn_mode  input  1  mode button level, debounced externally, synchronous to clk
- btn_inc  input  1  increment button level, debounced externally, synchronous to clk
- digOra  output  5  hours, binary 0..23
- digMinut  output  6  minutes, binary 0..59
- digSec  output  6  seconds, binary 0..59
- sec_tick  output  1  one-cycle pulse on each seconds increment
- edit_ora  output  1  high in SET_ORA state
- edit_min  output  1  high in SET_MIN state
- pm  output  1  PM flag; constant 0 unless DISP_12H_EN

Behaviour:
- Reset (reset_ low at a clk edge):
  - digOra, digMinut, digSec = 0; prescaler = 0; state = RUN; sec_tick = 0; edit_ora = edit_min = 0; pm = 0.
  - Button edge-detect history registers = 0.
- Reset asserted mid-operation (including in a set state) returns everything to the reset values on the next edge.
- Edge detection:
  - mode_evt = btn_mode & ~btn_mode_q; inc_evt = btn_inc & ~btn_inc_q.
  - History registers update every cycle.
  - A held button produces exactly one event.
- State machine: RUN -> SET_ORA -> SET_MIN -> RUN, advancing one step per mode_evt.
- RUN:
  - Prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and the seconds count increments in the same edge.
  - sec_tick is registered and high in the cycle where the new digSec value is first visible.
  - Period of sec_tick is exactly TICKS_PER_SEC cycles.
  - Seconds 59 -> 0 with carry to minutes; minutes 59 -> 0 with carry to hours; hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in a single edge.
  - inc_evt is ignored in RUN.
- SET_ORA:
  - Prescaler and seconds are frozen; sec_tick = 0.
  - Each inc_evt: digOra = (digOra == 23) ? 0 : digOra + 1. Minutes are unaffected.
- SET_MIN:
  - Prescaler and seconds are frozen.
  - Each inc_evt: digMinut = (digMinut == 59) ? 0 : digMinut + 1. No carry into hours.
- Leaving SET_MIN (mode_evt): digSec = 0, prescaler = 0. The first sec_tick occurs TICKS_PER_SEC cycles after the transition edge.
- Entering SET_ORA from RUN: the count freezes at its current value. A tick coinciding with that mode_evt edge is discarded.
- If mode_evt and inc_evt occur in the same cycle, mode_evt wins and inc_evt is dropped.
- edit_ora and edit_min are registered decodes of the state; they change on the same edge as the state.
- All outputs are registered. Adding the downstream divMod stage gives digits one cycle after digOra/digMinut change.

Optional Feature:
- Macro: DISP_12H_EN.
- Defined:
  - Internal hour stays 0..23 for counting and setting.
  - digOra presents 12-hour form: 0 -> 12, 1..12 -> 1..12, 13..23 -> 1..11.
  - pm = 1 when internal hour >= 12.
  - Conversion is registered in the same edge as the hour update, so there is no extra latency.
- Not defined: digOra = internal hour 0..23; pm tied to 0.

Test Plan:
All scenarios use TICKS_PER_SEC=4.
- Reset: hold reset_ low 3 cycles with buttons toggling -> all outputs 0, state RUN; first sec_tick 4 cycles after reset_ release, digSec=1.
- Full rollover: preset via set mode to 23:59, return to RUN, run 60 s (240 cycles) -> digOra=0, digMinut=0, digSec=0 on one edge, sec_tick high that cycle.
- Set mode: mode_evt -> edit_ora=1; 3 inc_evt from hour 22 -> 23, 0, 1. mode_evt -> edit_min=1; 2 inc_evt from 58 -> 59, 0, hour stays 1. mode_evt -> RUN, digSec=0, no sec_tick for 4 cycles.
- Held button: btn_inc high 20 cycles in SET_MIN -> exactly one increment. Simultaneous btn_mode/btn_inc rising edges in SET_ORA -> state SET_MIN, hour unchanged.
- Reset mid-edit: in SET_MIN at 05:17, assert reset_ one cycle -> 00:00:00, RUN, edit flags 0.
- DISP_12H_EN build: internal hours 0, 12, 13, 23 -> digOra=12/pm=0, 12/pm=1, 1/pm=1, 11/pm=1.
